vector_lsu: RTL and testbench

- Vector load/store unit sitting directly upstream of the 512 x 32-bit vector data memory.
- Accepts one vector memory request at a time from the issue stage over a valid/ready handshake, drives the memory's write/read enables and addresses, and captures the 16-word read result.
- Returns a completion or load response to the register-file writeback stage over a second valid/ready handshake.
- Rejects base addresses whose 16-word window would run past the top of memory.

---
 rtl/vec_pkg.sv | 32 +++
 rtl/vec_resp_reg.sv | 56 +++++
 rtl/vector_lsu.sv | 127 ++++++++++++
 tb/tb_vector_lsu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared constants, FSM state encoding and request record for the vector load/store unit.
package vec_pkg;

    localparam int ADDR_W    = 9;
    localparam int WORD_W    = 32;
    localparam int VLEN      = 16;
    localparam int MEM_DEPTH = 512;
    localparam int TAG_W     = 5;
    localparam int VEC_W     = VLEN * WORD_W;

    // Highest base whose 16-word window still fits below the top of memory.
    localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(MEM_DEPTH - VLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic              is_store;
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic [VEC_W-1:0]  wdata;
    } lsu_req_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr <= MAX_BASE;
    endfunction

endpackage

// File: rtl/vec_resp_reg.sv
// Single-entry valid/ready holding register for the LSU response toward writeback.
module vec_resp_reg
    import vec_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_is_store,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [VEC_W-1:0] i_rdata,
    input  logic             i_error,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_is_store,
    output logic [TAG_W-1:0] o_tag,
    output logic [VEC_W-1:0] o_rdata,
    output logic             o_error
);

    logic             r_valid;
    logic             r_is_store;
    logic [TAG_W-1:0] r_tag;
    logic [VEC_W-1:0] r_rdata;
    logic             r_error;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_is_store <= 1'b0;
            r_tag      <= '0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_is_store <= i_is_store;
            r_tag      <= i_tag;
            r_rdata    <= i_rdata;
            r_error    <= i_error;
        end else if (r_valid && i_ready) begin
            // Payload is cleared on hand-off so idle outputs read as zero.
            r_valid    <= 1'b0;
            r_is_store <= 1'b0;
            r_tag      <= '0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_is_store = r_is_store;
    assign o_tag      = r_tag;
    assign o_rdata    = r_rdata;
    assign o_error    = r_error;

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: one 16-word request at a time between issue, data memory and writeback.
module vector_lsu
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [VEC_W-1:0]  req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_is_store,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [VEC_W-1:0]  resp_rdata,
    output logic              resp_error,
    output logic              busy,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [VEC_W-1:0]  mem_wdata,
    input  logic [VEC_W-1:0]  mem_rdata
);

    lsu_state_t       r_state;
    lsu_state_t       w_state_next;
    lsu_req_t         r_req;

    logic             w_resp_load;
    logic             w_resp_is_store;
    logic [TAG_W-1:0] w_resp_tag;
    logic [VEC_W-1:0] w_resp_rdata;
    logic             w_resp_error;
    logic             w_resp_valid;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_resp_load     = 1'b0;
        w_resp_is_store = r_req.is_store;
        w_resp_tag      = r_req.tag;
        w_resp_rdata    = '0;
        w_resp_error    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (!addr_in_range(req_addr)) begin
                        // Out-of-window request answers straight from the live inputs.
                        w_state_next    = RESP;
                        w_resp_load     = 1'b1;
                        w_resp_is_store = req_is_store;
                        w_resp_tag      = req_tag;
                        w_resp_error    = 1'b1;
                    end else begin
                        w_state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (r_req.is_store) begin
                    w_state_next = RESP;
                    w_resp_load  = 1'b1;
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_state_next = RESP;
                w_resp_load  = 1'b1;
                w_resp_rdata = mem_rdata;
            end
            RESP: begin
                if (w_resp_valid && resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= '0;
        end else if (r_state == IDLE && req_valid) begin
            r_req <= '{is_store: req_is_store, addr: req_addr, tag: req_tag, wdata: req_wdata};
        end
    end

    vec_resp_reg u_resp_reg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_resp_load),
        .i_is_store (w_resp_is_store),
        .i_tag      (w_resp_tag),
        .i_rdata    (w_resp_rdata),
        .i_error    (w_resp_error),
        .i_ready    (resp_ready),
        .o_valid    (w_resp_valid),
        .o_is_store (resp_is_store),
        .o_tag      (resp_tag),
        .o_rdata    (resp_rdata),
        .o_error    (resp_error)
    );

    assign resp_valid = w_resp_valid;
    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);

    // Memory strobes decode straight from state so a reset drops them without waiting for an edge.
    assign mem_write_enable  = (r_state == ISSUE) && r_req.is_store;
    assign mem_read_enable   = (r_state == ISSUE) && !r_req.is_store;
    assign mem_write_address = mem_write_enable ? r_req.addr  : '0;
    assign mem_wdata         = mem_write_enable ? r_req.wdata : '0;
    assign mem_read_address  = mem_read_enable  ? r_req.addr  : '0;

endmodule

// File: tb/tb_vector_lsu.sv
// Directed self-checking bench for vector_lsu with a behavioural 512 x 32 data memory.
module tb_vector_lsu;
    import vec_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_is_store = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic [VEC_W-1:0]  req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic              resp_is_store;
    logic [TAG_W-1:0]  resp_tag;
    logic [VEC_W-1:0]  resp_rdata;
    logic              resp_error;
    logic              busy;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [ADDR_W-1:0] mem_write_address;
    logic [ADDR_W-1:0] mem_read_address;
    logic [VEC_W-1:0]  mem_wdata;
    logic [VEC_W-1:0]  mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int both_cnt = 0;

    logic [31:0] mem [0:MEM_DEPTH-1];

    vector_lsu dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_is_store      (req_is_store),
        .req_addr          (req_addr),
        .req_tag           (req_tag),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_is_store     (resp_is_store),
        .resp_tag          (resp_tag),
        .resp_rdata        (resp_rdata),
        .resp_error        (resp_error),
        .busy              (busy),
        .mem_write_enable  (mem_write_enable),
        .mem_read_enable   (mem_read_enable),
        .mem_write_address (mem_write_address),
        .mem_read_address  (mem_read_address),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'h5000_0000 + i;
        mem_rdata = '0;
    end

    // Memory model: synchronous write, read data registered one cycle after the enable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write_enable) wr_cnt <= wr_cnt + 1;
        if (mem_read_enable)  rd_cnt <= rd_cnt + 1;
        if (mem_write_enable && mem_read_enable) both_cnt <= both_cnt + 1;
        for (int k = 0; k < VLEN; k++) begin
            if (mem_write_enable && (int'(mem_write_address) + k) < MEM_DEPTH)
                mem[int'(mem_write_address) + k] <= mem_wdata[k*WORD_W +: WORD_W];
            if (mem_read_enable && (int'(mem_read_address) + k) < MEM_DEPTH)
                mem_rdata[k*WORD_W +: WORD_W] <= mem[int'(mem_read_address) + k];
        end
    end

    task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] vec(input logic [31:0] base);
        logic [VEC_W-1:0] v;
        for (int k = 0; k < VLEN; k++) v[k*WORD_W +: WORD_W] = base + 32'(k);
        return v;
    endfunction

    // Presents a request from just after an edge; returns with req_valid low, one cycle after acceptance.
    task automatic issue(input logic st, input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                         input logic [VEC_W-1:0] wd, output int acc);
        req_valid = 1'b1; req_is_store = st; req_addr = a; req_tag = t; req_wdata = wd;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin acc = cyc; break; end
            @(posedge clk); #1;
        end
        check("accept", VEC_W'(acc >= 0), VEC_W'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic get_resp(input string nm, input int acc, input int lat, input logic st,
                            input logic [TAG_W-1:0] t, input logic err, input logic [VEC_W-1:0] rd);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        check({nm, "_valid"}, VEC_W'(resp_valid), VEC_W'(1));
        check({nm, "_lat"}, VEC_W'(cyc - acc), VEC_W'(lat));
        check({nm, "_tag"}, VEC_W'(resp_tag), VEC_W'(t));
        check({nm, "_is_store"}, VEC_W'(resp_is_store), VEC_W'(st));
        check({nm, "_error"}, VEC_W'(resp_error), VEC_W'(err));
        check({nm, "_rdata"}, resp_rdata, rd);
        @(posedge clk); #1;
    endtask

    logic             b2b_st [3] = '{1'b1, 1'b0, 1'b0};
    logic [ADDR_W-1:0] b2b_a [3] = '{9'h040, 9'h040, 9'h1F0};
    logic [TAG_W-1:0] b2b_t  [3] = '{5'd1, 5'd2, 5'd4};
    int               b2b_lat[3] = '{2, 3, 3};
    int               acc_q  [3];
    int               rsp_c  [3];
    logic [TAG_W-1:0] rsp_t  [3];
    logic [VEC_W-1:0] rsp_d  [3];

    initial begin
        int acc;
        int wr0, rd0;
        logic [VEC_W-1:0] b2b_exp [3];

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", VEC_W'(req_ready), VEC_W'(1));
        check("rst_resp_valid", VEC_W'(resp_valid), VEC_W'(0));
        check("rst_busy", VEC_W'(busy), VEC_W'(0));
        check("rst_mem_we", VEC_W'(mem_write_enable), VEC_W'(0));
        check("rst_mem_re", VEC_W'(mem_read_enable), VEC_W'(0));
        check("rst_resp_rdata", resp_rdata, '0);
        check("rst_resp_tag", VEC_W'(resp_tag), VEC_W'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Store then load
        issue(1'b1, 9'h010, 5'd2, vec(32'hA000_0000), acc);
        get_resp("st010", acc, 2, 1'b1, 5'd2, 1'b0, '0);
        issue(1'b0, 9'h010, 5'd3, '0, acc);
        get_resp("ld010", acc, 3, 1'b0, 5'd3, 1'b0, vec(32'hA000_0000));
        check("ld010_ready_after", VEC_W'(req_ready), VEC_W'(1));

        // Address window boundary
        issue(1'b0, 9'd496, 5'd5, '0, acc);
        get_resp("ld496", acc, 3, 1'b0, 5'd5, 1'b0, vec(32'h5000_01F0));
        rd0 = rd_cnt;
        issue(1'b0, 9'd497, 5'd6, '0, acc);
        get_resp("ld497", acc, 1, 1'b0, 5'd6, 1'b1, '0);
        check("ld497_no_read", VEC_W'(rd_cnt), VEC_W'(rd0));

        // Backpressure with a competing request pending
        resp_ready = 1'b0;
        issue(1'b0, 9'h010, 5'd11, '0, acc);
        get_resp("bp", acc, 3, 1'b0, 5'd11, 1'b0, vec(32'hA000_0000));
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 9'h100; req_tag = 5'd12; req_wdata = vec(32'hC000_0000);
        wr0 = wr_cnt; rd0 = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", VEC_W'(resp_valid), VEC_W'(1));
            check("bp_tag", VEC_W'(resp_tag), VEC_W'(11));
            check("bp_rdata", resp_rdata, vec(32'hA000_0000));
            check("bp_req_ready", VEC_W'(req_ready), VEC_W'(0));
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", VEC_W'(resp_valid), VEC_W'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_done_ready", VEC_W'(req_ready), VEC_W'(1));
        check("bp_done_valid", VEC_W'(resp_valid), VEC_W'(0));
        check("bp_no_write", VEC_W'(wr_cnt), VEC_W'(wr0));
        check("bp_no_read", VEC_W'(rd_cnt), VEC_W'(rd0));
        @(posedge clk); #1;

        // Back-to-back: store, load, load with req_valid held
        b2b_exp[0] = '0;
        b2b_exp[1] = vec(32'hB000_0000);
        b2b_exp[2] = vec(32'h5000_01F0);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    req_valid = 1'b1; req_is_store = b2b_st[k]; req_addr = b2b_a[k];
                    req_tag = b2b_t[k]; req_wdata = vec(32'hB000_0000);
                    acc_q[k] = -1;
                    for (int i = 0; i < 50; i++) begin
                        @(negedge clk);
                        if (req_ready) begin acc_q[k] = cyc; break; end
                        @(posedge clk); #1;
                    end
                    @(posedge clk); #1;
                end
                req_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    rsp_c[k] = -1;
                    for (int i = 0; i < 60; i++) begin
                        @(negedge clk);
                        if (resp_valid) begin rsp_c[k] = cyc; rsp_t[k] = resp_tag; rsp_d[k] = resp_rdata; break; end
                        @(posedge clk); #1;
                    end
                    @(posedge clk); #1;
                end
            end
        join
        check("b2b_space_st", VEC_W'(acc_q[1] - acc_q[0]), VEC_W'(3));
        check("b2b_space_ld", VEC_W'(acc_q[2] - acc_q[1]), VEC_W'(4));
        for (int k = 0; k < 3; k++) begin
            check("b2b_lat", VEC_W'(rsp_c[k] - acc_q[k]), VEC_W'(b2b_lat[k]));
            check("b2b_tag", VEC_W'(rsp_t[k]), VEC_W'(b2b_t[k]));
            check("b2b_rdata", rsp_d[k], b2b_exp[k]);
        end

        // Store error leaves memory untouched
        wr0 = wr_cnt;
        issue(1'b1, 9'd511, 5'd8, vec(32'hDEAD_0000), acc);
        get_resp("st511", acc, 1, 1'b1, 5'd8, 1'b1, '0);
        check("st511_no_write", VEC_W'(wr_cnt), VEC_W'(wr0));
        issue(1'b0, 9'd496, 5'd9, '0, acc);
        get_resp("rb496", acc, 3, 1'b0, 5'd9, 1'b0, vec(32'h5000_01F0));

        // Reset during ISSUE drops the read strobe immediately
        issue(1'b0, 9'h020, 5'd14, '0, acc);
        check("iss_re_before", VEC_W'(mem_read_enable), VEC_W'(1));
        reset = 1'b1;
        #1;
        check("iss_rst_re", VEC_W'(mem_read_enable), VEC_W'(0));
        check("iss_rst_raddr", VEC_W'(mem_read_address), VEC_W'(0));
        check("iss_rst_ready", VEC_W'(req_ready), VEC_W'(1));
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset during WAIT, then a fresh load
        issue(1'b0, 9'h010, 5'd12, '0, acc);
        @(posedge clk); #1;
        check("wait_busy", VEC_W'(busy), VEC_W'(1));
        reset = 1'b1;
        #1;
        check("wait_rst_ready", VEC_W'(req_ready), VEC_W'(1));
        check("wait_rst_busy", VEC_W'(busy), VEC_W'(0));
        check("wait_rst_resp_valid", VEC_W'(resp_valid), VEC_W'(0));
        check("wait_rst_re", VEC_W'(mem_read_enable), VEC_W'(0));
        check("wait_rst_we", VEC_W'(mem_write_enable), VEC_W'(0));
        check("wait_rst_rdata", resp_rdata, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 9'h010, 5'd13, '0, acc);
        get_resp("ld_after_rst", acc, 3, 1'b0, 5'd13, 1'b0, vec(32'hA000_0000));

        check("never_both_enables", VEC_W'(both_cnt), VEC_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
